udma_ext_per_device: RTL
========================

# udma_ext_per_device

Peripheral-side endpoint of the uDMA external-peripheral streams, in the peripheral clock domain. It consumes 32-bit TX words from the uDMA TX clock-domain-crossing FIFO and serializes them LSB-first onto an 8-bit device stream. It packs 8-bit device RX bytes into 32-bit words for the uDMA RX clock-domain-crossing FIFO. Control comes from the 32-bit external setup word; status goes back on the external setup input.

## Interface
- No parameters. Byte width is fixed at 8 and word width at 32.
- `clk_i`  in  1  peripheral clock; single clock domain.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `cfg_setup_i`  in  32  quasi-static setup word, already synchronized:
  - [1:0] tx_size, [3:2] rx_size. For both: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
  - [8] tx_en, [9] rx_en.
  - [23:16] rx_timeout in cycles; 0 disables the timeout.
- `cfg_status_o`  out  32  status word:
  - [2:0] rx byte index, [4] tx_busy, [5] rx_partial.
  - [15:8] tx word count, [23:16] rx word count.
  - All other bits 0.
- `tx_data_i`  in  32  TX word from the uDMA.
- `tx_valid_i`  in  1  TX word valid.
- `tx_ready_o`  out  1  TX word accepted.
- `rx_data_o`  out  32  packed RX word to the uDMA.
- `rx_valid_o`  out  1  RX word valid.
- `rx_ready_i`  in  1  RX word taken.
- `per_tx_data_o`  out  8  byte to the device.
- `per_tx_valid_o`  out  1  device byte valid.
- `per_tx_ready_i`  in  1  device accepts byte.
- `per_rx_data_i`  in  8  byte from the device.
- `per_rx_valid_i`  in  1  device byte valid.
- `per_rx_ready_o`  out  1  endpoint accepts byte.

## Operation
- All handshakes are valid/ready. A transfer occurs on a rising edge with both high. Valid, once raised, is held with stable data until the transfer.

**TX serializer**
- FSM with two states, IDLE and SHIFT.
- IDLE: `tx_ready_o` = tx_en. On a TX handshake:
  - latch the word into the shift register;
  - latch nbytes from tx_size;
  - go to SHIFT.
- SHIFT: `per_tx_valid_o` = 1 and `per_tx_data_o` = shift[7:0]. On each device handshake:
  - shift right by 8 and decrement the remaining count;
  - on the last byte, go to IDLE and increment the tx word count (wraps at 8 bits).
- Clearing tx_en in SHIFT does not abort: the current word completes, then no new word is accepted.
- A tx_size change takes effect only at the next accept.
- Upper bytes beyond nbytes are discarded.

**RX packer**
- `per_rx_ready_o` = rx_en AND NOT `rx_valid_o`. There is a single output register, so bytes stall while a word is pending.
- Each accepted byte is written into lane `idx` and `idx` increments. rx_size is latched when `idx` = 0.
- When `idx`+1 = nbytes, the word is pushed:
  - `rx_valid_o` goes to 1;
  - the data is zero-extended above nbytes;
  - `idx` returns to 0 and the rx word count increments.
- Timeout:
  - The idle counter resets on every byte and counts while `idx` ≠ 0 with no byte accepted.
  - When it reaches rx_timeout (if nonzero), the partial word is pushed zero-extended.
  - If `rx_valid_o` is already high, the flush waits.
- Clearing rx_en with a partial word: the partial word is retained and the timeout can still flush it.
- `rx_valid_o` clears on `rx_ready_i`.

**Reset**
- Every output goes to 0.
- Both FSMs, `idx`, and all counters clear.
- Asserting reset mid-word drops the in-flight data.

## Timing
- TX latency: the first byte is valid one cycle after the word handshake.
- TX throughput: one byte per cycle while the device is ready, with one bubble cycle between words (ready only in IDLE).
- RX latency: `rx_valid_o` is registered and rises the cycle after the final byte handshake, or the cycle after the timeout match.
- `tx_ready_o` and `per_rx_ready_o` are combinational from state and configuration only. There are no combinational valid→ready paths.
- `cfg_status_o` is registered; one cycle stale.
- Simultaneous `rx_ready_i` and a final byte cannot occur, because `per_rx_ready_o` is low while `rx_valid_o` is high.

## Structure
- Package `udma_ext_per_pkg` holds:
  - the size enum (SZ_1B, SZ_2B, SZ_4B);
  - setup and status bit-position constants;
  - the function `nbytes(size)` returning 1, 2 or 4.
- Sub-module `udma_ext_per_ser`: the TX serializer FSM and shift register.
- The RX packer, timeout and status logic are inline in the top.

## Test plan
- **4-byte TX:** tx_size=2, tx_en=1, word 0xA1B2C3D4, device always ready → bytes D4, C3, B2, A1 on consecutive cycles; tx_ready_o low for 4 cycles; tx word count = 1.
- **Size change and backpressure:** tx_size=0, word 0x12345678 → single byte 0x78. Then tx_size=1 with per_tx_ready_i toggling → bytes 0x78, 0x56, each held stable while stalled.
- **2-byte RX:** rx_size=1, rx_en=1, bytes 0x11, 0x22 → rx_data_o = 0x00002211, valid the cycle after byte 2. With rx_ready_i held low, per_rx_ready_o stays 0 until the word is taken.
- **Timeout flush:** rx_size=2, rx_timeout=5, one byte 0xEE → rx_data_o = 0x000000EE after 5 idle cycles; rx_partial drops to 0.
- **Enable drop mid-word:** tx_en cleared during byte 2 of a 4-byte word → remaining bytes still sent and the next word is not accepted. rx_en cleared with `idx` = 2 → status idx = 2 is held.
- **Reset mid-operation:** assert rstn_i low during SHIFT → all outputs 0 asynchronously; after release, counters read 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/udma_ext_per_pkg.sv
// Shared definitions for the uDMA external-peripheral endpoint:
// transfer-size encoding, setup/status bit positions and the size decoder.
package udma_ext_per_pkg;

    // Transfer size field encoding. The value 3 also decodes to four bytes.
    typedef enum logic [1:0] {
        SZ_1B = 2'd0,
        SZ_2B = 2'd1,
        SZ_4B = 2'd2
    } size_e;

    // Bit positions inside the setup word
    localparam int SETUP_TX_SIZE = 0;   // [1:0]
    localparam int SETUP_RX_SIZE = 2;   // [3:2]
    localparam int SETUP_TX_EN   = 8;
    localparam int SETUP_RX_EN   = 9;
    localparam int SETUP_RX_TO   = 16;  // [23:16]

    // Bit positions inside the status word
    localparam int STAT_IDX        = 0;  // [2:0]
    localparam int STAT_TX_BUSY    = 4;
    localparam int STAT_RX_PARTIAL = 5;
    localparam int STAT_TX_CNT     = 8;  // [15:8]
    localparam int STAT_RX_CNT     = 16; // [23:16]

    // Number of bytes carried by one word for a given size field
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size_e'(size))
            SZ_1B:   n = 3'd1;
            SZ_2B:   n = 3'd2;
            SZ_4B:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/udma_ext_per_ser.sv
// TX serializer: takes one 32-bit word and emits its low 1, 2 or 4 bytes
// LSB-first on the 8-bit device stream. Two-state FSM (IDLE / SHIFT).
module udma_ext_per_ser
    import udma_ext_per_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,          // word acceptance enable (tx_en, gated by reset state)
    input  logic [1:0]  size,        // tx_size field, sampled only at word accept
    input  logic [31:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic [7:0]  word_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]  state_reg;
    logic [31:0] shift_reg;
    logic [2:0]  rem_reg;
    logic [7:0]  cnt_reg;

    // Ready depends only on state and enable; no path from word_valid
    assign word_ready = (state_reg == ST_IDLE) && en;
    assign byte_valid = (state_reg == ST_SHIFT);
    assign byte_data  = shift_reg[7:0];
    assign busy       = (state_reg == ST_SHIFT);
    assign word_cnt   = cnt_reg;

    // FSM, shift register, remaining-byte count and completed-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (word_valid && word_ready) begin
                        shift_reg <= word_data;
                        rem_reg   <= nbytes(size);
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (byte_ready) begin
                        if (rem_reg == 3'd1) begin
                            // Last byte gone: drop any unsent upper bytes
                            shift_reg <= '0;
                            rem_reg   <= '0;
                            cnt_reg   <= cnt_reg + 8'd1;
                            state_reg <= ST_IDLE;
                        end else begin
                            shift_reg <= {8'h00, shift_reg[31:8]};
                            rem_reg   <= rem_reg - 3'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/udma_ext_per_device.sv
// Peripheral-side endpoint of the uDMA external streams. TX words are
// serialized onto the device byte stream by udma_ext_per_ser; device RX
// bytes are packed here into words, with an idle timeout that flushes a
// partial word. Status is reported one cycle late through cfg_status_o.
module udma_ext_per_device
    import udma_ext_per_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] cfg_setup_i,
    output logic [31:0] cfg_status_o,
    input  logic [31:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [7:0]  per_tx_data_o,
    output logic        per_tx_valid_o,
    input  logic        per_tx_ready_i,
    input  logic [7:0]  per_rx_data_i,
    input  logic        per_rx_valid_i,
    output logic        per_rx_ready_o
);

    // Setup word fields
    logic [1:0] tx_size;
    logic [1:0] rx_size;
    logic       tx_en;
    logic       rx_en;
    logic [7:0] rx_timeout;
    logic       cfg_unused;

    assign tx_size    = cfg_setup_i[SETUP_TX_SIZE +: 2];
    assign rx_size    = cfg_setup_i[SETUP_RX_SIZE +: 2];
    assign tx_en      = cfg_setup_i[SETUP_TX_EN];
    assign rx_en      = cfg_setup_i[SETUP_RX_EN];
    assign rx_timeout = cfg_setup_i[SETUP_RX_TO +: 8];
    assign cfg_unused = ^{cfg_setup_i[31:24], cfg_setup_i[15:10], cfg_setup_i[7:4]};

    // Low while in reset so that both ready outputs are 0 during reset,
    // rises on the first clock after release.
    logic active_reg;

    // Out-of-reset flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic       tx_busy;
    logic [7:0] tx_cnt;

    udma_ext_per_ser u_ser (
        .clk        (clk_i),
        .rst_n      (rstn_i),
        .en         (active_reg && tx_en),
        .size       (tx_size),
        .word_data  (tx_data_i),
        .word_valid (tx_valid_i),
        .word_ready (tx_ready_o),
        .byte_data  (per_tx_data_o),
        .byte_valid (per_tx_valid_o),
        .byte_ready (per_tx_ready_i),
        .busy       (tx_busy),
        .word_cnt   (tx_cnt)
    );

    // ------------------------------------------------------------------
    // RX packer
    // ------------------------------------------------------------------
    logic [2:0]  idx_reg;      // next byte lane; nonzero means a partial word
    logic [2:0]  nb_reg;       // word size latched at the first byte
    logic [31:0] buf_reg;      // partial word, zero above the filled lanes
    logic [7:0]  to_cnt_reg;   // idle cycles since the last accepted byte
    logic [31:0] rx_data_reg;
    logic        rx_valid_reg;
    logic [7:0]  rx_cnt_reg;
    logic [31:0] status_reg;

    logic        byte_acc;
    logic [2:0]  nb_eff;
    logic [31:0] buf_wr;
    logic        last_byte;
    logic [7:0]  to_cnt_inc;
    logic        to_hit;
    logic        flush;
    logic [31:0] status_next;

    // A single output register: stall bytes while a word waits for the uDMA
    assign per_rx_ready_o = active_reg && rx_en && !rx_valid_reg;
    assign rx_data_o      = rx_data_reg;
    assign rx_valid_o     = rx_valid_reg;
    assign cfg_status_o   = status_reg;

    assign byte_acc   = per_rx_valid_i && per_rx_ready_o;
    assign nb_eff     = (idx_reg == 3'd0) ? nbytes(rx_size) : nb_reg;
    assign last_byte  = byte_acc && ((idx_reg + 3'd1) == nb_eff);
    // Saturate so that a flush held off by a pending word is not lost to wrap
    assign to_cnt_inc = (to_cnt_reg == 8'hFF) ? 8'hFF : (to_cnt_reg + 8'd1);
    assign to_hit     = (idx_reg != 3'd0) && !byte_acc &&
                        (rx_timeout != 8'd0) && (to_cnt_inc >= rx_timeout);
    assign flush      = to_hit && !rx_valid_reg;

    // Partial word with the incoming byte placed in its lane
    always_comb begin
        buf_wr = buf_reg;
        buf_wr[{idx_reg[1:0], 3'b000} +: 8] = per_rx_data_i;
    end

    // Byte packing, timeout flush and output word register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_reg      <= '0;
            nb_reg       <= '0;
            buf_reg      <= '0;
            to_cnt_reg   <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_cnt_reg   <= '0;
        end else begin
            if (rx_valid_reg && rx_ready_i) begin
                rx_valid_reg <= 1'b0;
            end

            if (byte_acc) begin
                to_cnt_reg <= '0;
                if (idx_reg == 3'd0) begin
                    nb_reg <= nbytes(rx_size);
                end
                if (last_byte) begin
                    rx_data_reg  <= buf_wr;
                    rx_valid_reg <= 1'b1;
                    buf_reg      <= '0;
                    idx_reg      <= '0;
                    rx_cnt_reg   <= rx_cnt_reg + 8'd1;
                end else begin
                    buf_reg <= buf_wr;
                    idx_reg <= idx_reg + 3'd1;
                end
            end else if (idx_reg != 3'd0) begin
                if (flush) begin
                    rx_data_reg  <= buf_reg;
                    rx_valid_reg <= 1'b1;
                    buf_reg      <= '0;
                    idx_reg      <= '0;
                    to_cnt_reg   <= '0;
                    rx_cnt_reg   <= rx_cnt_reg + 8'd1;
                end else begin
                    to_cnt_reg <= to_cnt_inc;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------

    // Assemble the status word from current state
    always_comb begin
        status_next = '0;
        status_next[STAT_IDX +: 3]      = idx_reg;
        status_next[STAT_TX_BUSY]       = tx_busy;
        status_next[STAT_RX_PARTIAL]    = (idx_reg != 3'd0);
        status_next[STAT_TX_CNT +: 8]   = tx_cnt;
        status_next[STAT_RX_CNT +: 8]   = rx_cnt_reg;
    end

    // Registered status, one cycle behind the state it reports
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

endmodule
